// File: rtl/flash_io_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : flash_io_sequencer
// Streams NUM_BYTES bytes from SPI flash (READ 0x03 at FLASH_BASE) onto the
// low user IO pads, holding each byte for HOLD_CYCLES clocks.
// Option  : FLASH_SEQ_LOOP_EN restarts the pass after DONE.
// Revision: 1.0 - initial release
// ============================================================================
module flash_io_sequencer #(
    parameter logic [23:0] FLASH_BASE  = 24'h000000,
    parameter int          NUM_BYTES   = 12,
    parameter int          HOLD_CYCLES = 16
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    output logic       flash_csb,
    output logic       flash_clk,
    output logic       flash_io0,
    input  logic       flash_io1,
    output logic [7:0] io_out,
    output logic [7:0] io_oeb,
    output logic       busy,
    output logic       done
);

    localparam int                HOLD_EFF    = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
    localparam int                HOLD_W      = (HOLD_EFF > 1) ? $clog2(HOLD_EFF) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_EFF - 1);
    localparam logic [15:0]       BYTES_TOTAL = 16'(NUM_BYTES);
    localparam logic [31:0]       READ_CMD    = {8'h03, FLASH_BASE};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_DATA = 3'd2,
        S_HOLD = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state;
    logic              idle_wait;
    logic              phase_b;
    logic [4:0]        bit_cnt;
    logic [30:0]       cmd_sr;
    logic [7:0]        rx_sr;
    logic [15:0]       byte_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= S_IDLE;
            idle_wait <= 1'b1;
            phase_b   <= 1'b0;
            bit_cnt   <= 5'd0;
            cmd_sr    <= 31'd0;
            rx_sr     <= 8'h00;
            byte_cnt  <= 16'd0;
            hold_cnt  <= '0;
            flash_csb <= 1'b1;
            flash_clk <= 1'b0;
            flash_io0 <= 1'b0;
            io_out    <= 8'h00;
            io_oeb    <= 8'hFF;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // First clock after reset is a dwell; loop restarts skip it
                    if (idle_wait) begin
                        idle_wait <= 1'b0;
                    end else if (NUM_BYTES == 0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state     <= S_CMD;
                        flash_csb <= 1'b0;
                        busy      <= 1'b1;
                        flash_io0 <= READ_CMD[31];
                        cmd_sr    <= READ_CMD[30:0];
                        bit_cnt   <= 5'd0;
                        phase_b   <= 1'b0;
                        byte_cnt  <= 16'd0;
                    end
                end

                S_CMD: begin
                    if (!phase_b) begin
                        flash_clk <= 1'b1;
                        phase_b   <= 1'b1;
                    end else begin
                        flash_clk <= 1'b0;
                        phase_b   <= 1'b0;
                        if (bit_cnt == 5'd31) begin
                            state     <= S_DATA;
                            flash_io0 <= 1'b0;
                            bit_cnt   <= 5'd0;
                        end else begin
                            flash_io0 <= cmd_sr[30];
                            cmd_sr    <= {cmd_sr[29:0], 1'b0};
                            bit_cnt   <= bit_cnt + 5'd1;
                        end
                    end
                end

                S_DATA: begin
                    // MISO is captured on the same edge that raises flash_clk
                    if (!phase_b) begin
                        flash_clk <= 1'b1;
                        phase_b   <= 1'b1;
                        rx_sr     <= {rx_sr[6:0], flash_io1};
                    end else begin
                        flash_clk <= 1'b0;
                        phase_b   <= 1'b0;
                        if (bit_cnt == 5'd7) begin
                            io_out   <= rx_sr;
                            io_oeb   <= 8'h00;
                            byte_cnt <= byte_cnt + 16'd1;
                            bit_cnt  <= 5'd0;
                            hold_cnt <= '0;
                            state    <= S_HOLD;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end

                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        if (byte_cnt == BYTES_TOTAL) begin
                            state     <= S_DONE;
                            flash_csb <= 1'b1;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end

                S_DONE: begin
`ifdef FLASH_SEQ_LOOP_EN
                    done  <= 1'b0;
                    state <= S_IDLE;
`else
                    state <= S_DONE;
`endif
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_flash_io_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_flash_io_sequencer
// Directed bench: several sequencer configurations, each with a flash model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_flash_io_sequencer;

    localparam int N = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 0: main 12-byte image, 1: base 0x100000, 2: zero bytes, 3: hold 0, 4: hold 1
    function automatic logic [23:0] cfg_base(int k);
        return (k == 1) ? 24'h100000 : 24'h000000;
    endfunction

    function automatic int cfg_num(int k);
        case (k)
            0:       return 12;
            2:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic int cfg_hold(int k);
        case (k)
            0:       return 16;
            1:       return 2;
            2:       return 4;
            3:       return 0;
            default: return 1;
        endcase
    endfunction

    function automatic logic [7:0] img_byte(int k, int idx);
        int j;
        if (k == 0) begin
            j = idx % 12;
            if (j < 10)       return 8'(j + 1);
            else if (j == 10) return 8'hFF;
            else              return 8'h00;
        end
        case (idx % 3)
            0:       return 8'hAA;
            1:       return 8'h55;
            default: return 8'hC3;
        endcase
    endfunction

    for (genvar i = 0; i < N; i++) begin : g_dut
        logic        csb, fclk, io0, busy, done;
        logic [7:0]  io_out, oeb;
        logic        miso     = 1'b0;
        logic        fq       = 1'b0;
        int          rises    = 0;
        logic [31:0] cap      = 32'd0;
        logic [31:0] cmd_seen = 32'd0;
        logic [7:0]  last     = 8'h00;
        logic [7:0]  ev_val[$];
        int          ev_cyc[$];
        logic        ev_done[$];
        int          gaps[$];
        int          dpulses[$];
        int          low_seen = 0;
        int          run      = 0;
        int          drun     = 0;

        flash_io_sequencer #(
            .FLASH_BASE (cfg_base(i)),
            .NUM_BYTES  (cfg_num(i)),
            .HOLD_CYCLES(cfg_hold(i))
        ) u_dut (
            .wb_clk_i (clk),
            .wb_rst_i (rst),
            .flash_csb(csb),
            .flash_clk(fclk),
            .flash_io0(io0),
            .flash_io1(miso),
            .io_out   (io_out),
            .io_oeb   (oeb),
            .busy     (busy),
            .done     (done)
        );

        // Mode-0 flash: shift in on SCK rise, drive next data bit after SCK fall
        always @(negedge clk) begin
            logic [7:0] b;
            int         j;
            if (csb) begin
                rises = 0;
                cap   = 32'd0;
                miso  = 1'b0;
            end else if (fclk && !fq) begin
                if (rises < 32) cap = {cap[30:0], io0};
                rises++;
                if (rises == 32) cmd_seen = cap;
            end else if (!fclk && fq && rises >= 32) begin
                j    = rises - 32;
                b    = img_byte(i, j / 8);
                miso = b[7 - (j % 8)];
            end
            fq = fclk;

            if (rst) begin
                ev_val.delete();
                ev_cyc.delete();
                ev_done.delete();
                gaps.delete();
                dpulses.delete();
                last     = 8'h00;
                low_seen = 0;
                run      = 0;
                drun     = 0;
            end else begin
                if (io_out != last) begin
                    ev_val.push_back(io_out);
                    ev_cyc.push_back(cyc);
                    ev_done.push_back(done);
                    last = io_out;
                end
                if (!csb) begin
                    if (low_seen != 0 && run > 0) gaps.push_back(run);
                    run      = 0;
                    low_seen = 1;
                end else begin
                    run++;
                end
                if (done) drun++;
                else if (drun > 0) begin
                    dpulses.push_back(drun);
                    drun = 0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, r1, r2, t;

        repeat (3) @(negedge clk);
        check("rst_csb",  32'(g_dut[0].csb),    32'd1);
        check("rst_fclk", 32'(g_dut[0].fclk),   32'd0);
        check("rst_io0",  32'(g_dut[0].io0),    32'd0);
        check("rst_out",  32'(g_dut[0].io_out), 32'h00);
        check("rst_oeb",  32'(g_dut[0].oeb),    32'hFF);
        check("rst_busy", 32'(g_dut[0].busy),   32'd0);
        check("rst_done", 32'(g_dut[0].done),   32'd0);

        rst = 1'b0;
        r0  = cyc;
        @(negedge clk);
        check("zero_done_c1", 32'(g_dut[2].done), 32'd0);
        @(negedge clk);
        check("zero_done_c2", 32'(g_dut[2].done), 32'd1);
        check("main_csb_c2",  32'(g_dut[0].csb),  32'd0);
        check("main_busy_c2", 32'(g_dut[0].busy), 32'd1);

        t = 0;
        while (t < 600 && !g_dut[0].done) begin
            @(negedge clk);
            t++;
        end
        check("main_done_timeout", 32'(g_dut[0].done), 32'd1);

        check("main_nbytes", 32'(g_dut[0].ev_val.size()), 32'd12);
        for (int k = 0; k < 12; k++) begin
            if (k < g_dut[0].ev_val.size()) begin
                check($sformatf("main_byte%0d", k), 32'(g_dut[0].ev_val[k]), 32'(img_byte(0, k)));
                if (k == 0)
                    check("main_first_cyc", 32'(g_dut[0].ev_cyc[0] - r0), 32'd82);
                else
                    check($sformatf("main_period%0d", k),
                          32'(g_dut[0].ev_cyc[k] - g_dut[0].ev_cyc[k-1]), 32'd32);
            end
        end
        if (g_dut[0].ev_done.size() == 12)
            check("main_done_at_last", 32'(g_dut[0].ev_done[11]), 32'd0);

        check("cmd_base0",   g_dut[0].cmd_seen, 32'h03000000);
        check("cmd_base1",   g_dut[1].cmd_seen, 32'h03100000);
        check("base1_byte0", 32'(g_dut[1].ev_val.size() > 0 ? g_dut[1].ev_val[0] : 8'h00), 32'hAA);

        for (int d = 3; d <= 4; d++) begin
            for (int k = 0; k < 3; k++) begin
                if (d == 3) begin
                    check($sformatf("h0_byte%0d", k),
                          32'(k < g_dut[3].ev_val.size() ? g_dut[3].ev_val[k] : 8'h00), 32'(img_byte(3, k)));
                    check($sformatf("h0_cyc%0d", k),
                          32'(k < g_dut[3].ev_cyc.size() ? g_dut[3].ev_cyc[k] - r0 : 0), 32'(82 + 17 * k));
                end else begin
                    check($sformatf("h1_byte%0d", k),
                          32'(k < g_dut[4].ev_val.size() ? g_dut[4].ev_val[k] : 8'h00), 32'(img_byte(4, k)));
                    check($sformatf("h1_cyc%0d", k),
                          32'(k < g_dut[4].ev_cyc.size() ? g_dut[4].ev_cyc[k] - r0 : 0), 32'(82 + 17 * k));
                end
            end
        end

        check("zero_csb_never_low", 32'(g_dut[2].low_seen), 32'd0);
        check("zero_oeb",           32'(g_dut[2].oeb),      32'hFF);

`ifdef FLASH_SEQ_LOOP_EN
        check("loop_byte3", 32'(g_dut[3].ev_val.size() > 3 ? g_dut[3].ev_val[3] : 8'h00), 32'hAA);
        check("loop_byte4", 32'(g_dut[3].ev_val.size() > 4 ? g_dut[3].ev_val[4] : 8'h00), 32'h55);
        check("loop_byte5", 32'(g_dut[3].ev_val.size() > 5 ? g_dut[3].ev_val[5] : 8'h00), 32'hC3);
        check("loop_restart_cyc", 32'(g_dut[3].ev_cyc.size() > 3 ? g_dut[3].ev_cyc[3] - r0 : 0), 32'd199);
        check("loop_csb_gap",   32'(g_dut[3].gaps.size() > 0 ? g_dut[3].gaps[0] : 0), 32'd2);
        check("loop_done_width", 32'(g_dut[3].dpulses.size() > 0 ? g_dut[3].dpulses[0] : 0), 32'd1);
`else
        repeat (20) @(negedge clk);
        check("term_done",   32'(g_dut[0].done),   32'd1);
        check("term_csb",    32'(g_dut[0].csb),    32'd1);
        check("term_busy",   32'(g_dut[0].busy),   32'd0);
        check("term_io_out", 32'(g_dut[0].io_out), 32'h00);
        check("term_oeb",    32'(g_dut[0].oeb),    32'h00);
        check("term_h0_out", 32'(g_dut[3].io_out), 32'hC3);
`endif

        // Reset in the middle of the fourth byte's data phase
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        r1  = cyc;
        repeat (170) @(negedge clk);
        check("mid_nbytes", 32'(g_dut[0].ev_val.size()), 32'd3);
        check("mid_busy",   32'(g_dut[0].busy),          32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_csb",  32'(g_dut[0].csb),    32'd1);
        check("abort_fclk", 32'(g_dut[0].fclk),   32'd0);
        check("abort_out",  32'(g_dut[0].io_out), 32'h00);
        check("abort_oeb",  32'(g_dut[0].oeb),    32'hFF);
        check("abort_busy", 32'(g_dut[0].busy),   32'd0);
        rst = 1'b0;
        r2  = cyc;
        repeat (90) @(negedge clk);
        check("restart_byte0", 32'(g_dut[0].ev_val.size() > 0 ? g_dut[0].ev_val[0] : 8'h00), 32'h01);
        check("restart_cyc",   32'(g_dut[0].ev_cyc.size() > 0 ? g_dut[0].ev_cyc[0] - r2 : 0), 32'd82);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
